bp_btb_bht: RTL and testbench

- Parametrised branch predictor for the 5-stage RV32I pipeline: direct-mapped BTB, per-entry N-bit saturating direction counters, optional gshare global-history indexing.
- Fetch-stage lookup is combinational on pc_f, so the next PC is ready in the same cycle.
- Training, mispredict detection and redirect PC come from branches/jumps resolved in Execute.
- Adds accuracy counters for debug.

---
 rtl/bp_btb_bht_if.sv | 40 ++++
 rtl/bp_btb_bht.sv | 122 ++++++++++++
 tb/tb_bp_btb_bht.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_btb_bht_if.sv
// Fetch-lookup and Execute-resolve bus for the bp_btb_bht branch predictor.
// Widths must match the predictor's XLEN and max(GHR_BITS,1).
interface bp_btb_bht_if #(
    parameter int XLEN  = 32,
    parameter int GHR_W = 1
);
    logic [XLEN-1:0]  pc_f;
    logic             pred_taken_f;
    logic [XLEN-1:0]  pred_target_f;
    logic [GHR_W-1:0] pred_ghr_f;

    logic             upd_vld;
    logic             upd_is_br;
    logic             upd_is_jmp;
    logic [XLEN-1:0]  upd_pc;
    logic [GHR_W-1:0] upd_ghr;
    logic             upd_taken;
    logic [XLEN-1:0]  upd_target;
    logic             upd_pred_taken;
    logic [XLEN-1:0]  upd_pred_target;

    logic             mispredict;
    logic [XLEN-1:0]  redirect_pc;
    logic [31:0]      br_cnt;
    logic [31:0]      miss_cnt;

    modport master (
        output pc_f, upd_vld, upd_is_br, upd_is_jmp, upd_pc, upd_ghr,
               upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        input  pred_taken_f, pred_target_f, pred_ghr_f,
               mispredict, redirect_pc, br_cnt, miss_cnt
    );

    modport slave (
        input  pc_f, upd_vld, upd_is_br, upd_is_jmp, upd_pc, upd_ghr,
               upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        output pred_taken_f, pred_target_f, pred_ghr_f,
               mispredict, redirect_pc, br_cnt, miss_cnt
    );
endinterface

// File: rtl/bp_btb_bht.sv
// Direct-mapped BTB with per-entry saturating direction counters and optional
// gshare indexing; combinational fetch lookup, training from Execute.
module bp_btb_bht #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int TAG_BITS = 8,
    parameter int CTR_BITS = 2,
    parameter int GHR_BITS = 0
) (
    input logic          clk,
    input logic          rst,
    bp_btb_bht_if.slave  bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int GHR_W = (GHR_BITS > 0) ? GHR_BITS : 1;

    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

    logic [GHR_W-1:0]    ghr_q;
    logic [31:0]         br_cnt_q;
    logic [31:0]         miss_cnt_q;

    logic [IDX_W-1:0]    f_idx;
    logic                f_hit;
    logic                upd_gate;
    logic [IDX_W-1:0]    u_idx;
    logic [TAG_BITS-1:0] u_tag;
    logic                u_hit;
    logic [CTR_BITS-1:0] u_ctr_nxt;

    function automatic logic [IDX_W-1:0] idx_of(input logic [XLEN-1:0] pc,
                                                 input logic [GHR_W-1:0] h);
        logic [IDX_W-1:0] hx;
        hx = (GHR_BITS > 0) ? IDX_W'(h) : '0;
        return pc[IDX_W+1:2] ^ hx;
    endfunction

    function automatic logic [TAG_BITS-1:0] tag_of(input logic [XLEN-1:0] pc);
        return pc[IDX_W+TAG_BITS+1:IDX_W+2];
    endfunction

    // Lookup reads the registered arrays, so a same-cycle update is not visible yet
    always_comb begin
        f_idx            = idx_of(bp.pc_f, ghr_q);
        f_hit            = valid_q[f_idx] && (tag_q[f_idx] == tag_of(bp.pc_f));
        bp.pred_taken_f  = f_hit && ctr_q[f_idx][CTR_BITS-1];
        bp.pred_target_f = bp.pred_taken_f ? target_q[f_idx] : bp.pc_f + XLEN'(4);
    end

    assign bp.pred_ghr_f = ghr_q;

    always_comb begin
        upd_gate       = bp.upd_vld && (bp.upd_is_br || bp.upd_is_jmp);
        bp.mispredict  = upd_gate &&
                         ((bp.upd_taken != bp.upd_pred_taken) ||
                          (bp.upd_taken && (bp.upd_target != bp.upd_pred_target)));
        bp.redirect_pc = bp.upd_taken ? bp.upd_target : bp.upd_pc + XLEN'(4);
    end

    always_comb begin
        u_idx = idx_of(bp.upd_pc, bp.upd_ghr);
        u_tag = tag_of(bp.upd_pc);
        u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        if (bp.upd_taken)
            u_ctr_nxt = (ctr_q[u_idx] == CTR_MAX) ? ctr_q[u_idx] : ctr_q[u_idx] + 1'b1;
        else
            u_ctr_nxt = (ctr_q[u_idx] == '0) ? ctr_q[u_idx] : ctr_q[u_idx] - 1'b1;
    end

    // Jumps take priority over branches on the entry; allocation only on taken
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[IDX_W'(i)] <= 1'b0;
                ctr_q[IDX_W'(i)]   <= CTR_WNT;
            end
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else if (upd_gate) begin
            br_cnt_q <= br_cnt_q + 32'd1;
            if (bp.mispredict)
                miss_cnt_q <= miss_cnt_q + 32'd1;
            if (u_hit) begin
                if (bp.upd_is_jmp) begin
                    ctr_q[u_idx]    <= CTR_MAX;
                    target_q[u_idx] <= bp.upd_target;
                end else begin
                    ctr_q[u_idx] <= u_ctr_nxt;
                    if (bp.upd_taken)
                        target_q[u_idx] <= bp.upd_target;
                end
            end else if (bp.upd_taken) begin
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= bp.upd_target;
                ctr_q[u_idx]    <= bp.upd_is_jmp ? CTR_MAX : CTR_WT;
            end
        end
    end

    // History is rebuilt from the resolving branch's own snapshot, repairing it after a flush
    if (GHR_BITS > 0) begin : g_gshare
        always_ff @(posedge clk) begin
            if (rst)
                ghr_q <= '0;
            else if (upd_gate && bp.upd_is_br)
                ghr_q <= (bp.upd_ghr << 1) | GHR_W'(bp.upd_taken);
        end
    end else begin : g_bimodal
        assign ghr_q = '0;
    end

    assign bp.br_cnt   = br_cnt_q;
    assign bp.miss_cnt = miss_cnt_q;
endmodule

// File: tb/tb_bp_btb_bht.sv
// Bench for bp_btb_bht: a bimodal and a 2-bit gshare instance driven in parallel,
// checked against an array-based predictor model plus directed constants.
module tb_bp_btb_bht;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] pc_f, upd_pc, upd_target, upd_pred_target;
    logic        upd_vld, upd_is_br, upd_is_jmp, upd_taken, upd_pred_taken;
    logic [0:0]  ghr0;
    logic [1:0]  ghr1;

    bp_btb_bht_if #(.XLEN(32), .GHR_W(1)) b0 ();
    bp_btb_bht_if #(.XLEN(32), .GHR_W(2)) b1 ();

    assign b0.pc_f = pc_f;               assign b1.pc_f = pc_f;
    assign b0.upd_vld = upd_vld;         assign b1.upd_vld = upd_vld;
    assign b0.upd_is_br = upd_is_br;     assign b1.upd_is_br = upd_is_br;
    assign b0.upd_is_jmp = upd_is_jmp;   assign b1.upd_is_jmp = upd_is_jmp;
    assign b0.upd_pc = upd_pc;           assign b1.upd_pc = upd_pc;
    assign b0.upd_ghr = ghr0;            assign b1.upd_ghr = ghr1;
    assign b0.upd_taken = upd_taken;     assign b1.upd_taken = upd_taken;
    assign b0.upd_target = upd_target;   assign b1.upd_target = upd_target;
    assign b0.upd_pred_taken = upd_pred_taken;
    assign b1.upd_pred_taken = upd_pred_taken;
    assign b0.upd_pred_target = upd_pred_target;
    assign b1.upd_pred_target = upd_pred_target;

    bp_btb_bht #(.XLEN(32), .ENTRIES(16), .TAG_BITS(8), .CTR_BITS(2), .GHR_BITS(0))
        u_bimodal (.clk(clk), .rst(rst), .bp(b0.slave));
    bp_btb_bht #(.XLEN(32), .ENTRIES(16), .TAG_BITS(8), .CTR_BITS(2), .GHR_BITS(2))
        u_gshare (.clk(clk), .rst(rst), .bp(b1.slave));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: k=0 bimodal, k=1 gshare over 2 history bits
    bit          mv   [2][16];
    logic [7:0]  mtag [2][16];
    logic [31:0] mtgt [2][16];
    int          mctr [2][16];
    int          mghr [2];
    logic [31:0] mbr  [2];
    logic [31:0] mmiss[2];

    function automatic int midx(input int k, input logic [31:0] pc, input int h);
        return int'((pc >> 2) % 16) ^ ((k == 1) ? h : 0);
    endfunction

    function automatic bit gated();
        return (upd_vld === 1'b1) && ((upd_is_br === 1'b1) || (upd_is_jmp === 1'b1));
    endfunction

    function automatic bit exp_mis();
        if (!gated()) return 1'b0;
        return (upd_taken != upd_pred_taken) || (upd_taken && (upd_target != upd_pred_target));
    endfunction

    task automatic settle();
        #1;
        for (int k = 0; k < 2; k++) begin
            int          e   = midx(k, pc_f, mghr[k]);
            bit          hit = mv[k][e] && (mtag[k][e] == pc_f[13:6]);
            bit          pt  = hit && (mctr[k][e] >= 2);
            logic [31:0] tg  = pt ? mtgt[k][e] : pc_f + 32'd4;
            logic [31:0] rd  = upd_taken ? upd_target : upd_pc + 32'd4;
            string       p   = (k == 0) ? "bim" : "gsh";
            check({p, ".pred_taken"},  (k == 0) ? 32'(b0.pred_taken_f)  : 32'(b1.pred_taken_f), 32'(pt));
            check({p, ".pred_target"}, (k == 0) ? b0.pred_target_f      : b1.pred_target_f, tg);
            check({p, ".pred_ghr"},    (k == 0) ? 32'(b0.pred_ghr_f)    : 32'(b1.pred_ghr_f), 32'(mghr[k]));
            check({p, ".mispredict"},  (k == 0) ? 32'(b0.mispredict)    : 32'(b1.mispredict), 32'(exp_mis()));
            if (gated())
                check({p, ".redirect"}, (k == 0) ? b0.redirect_pc : b1.redirect_pc, rd);
            check({p, ".br_cnt"},   (k == 0) ? b0.br_cnt   : b1.br_cnt,   mbr[k]);
            check({p, ".miss_cnt"}, (k == 0) ? b0.miss_cnt : b1.miss_cnt, mmiss[k]);
        end
    endtask

    task automatic tick();
        bit mis;
        mis = exp_mis();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < 16; i++) begin
                    mv[k][i]   = 1'b0;
                    mctr[k][i] = 1;
                end
                mghr[k] = 0; mbr[k] = 0; mmiss[k] = 0;
            end else if (gated()) begin
                int h   = (k == 1) ? int'(ghr1) : 0;
                int e   = midx(k, upd_pc, h);
                bit hit = mv[k][e] && (mtag[k][e] == upd_pc[13:6]);
                if (hit && upd_is_jmp) begin
                    mctr[k][e] = 3;
                    mtgt[k][e] = upd_target;
                end else if (hit) begin
                    if (upd_taken) begin
                        if (mctr[k][e] < 3) mctr[k][e]++;
                        mtgt[k][e] = upd_target;
                    end else if (mctr[k][e] > 0) begin
                        mctr[k][e]--;
                    end
                end else if (upd_taken) begin
                    mv[k][e]   = 1'b1;
                    mtag[k][e] = upd_pc[13:6];
                    mtgt[k][e] = upd_target;
                    mctr[k][e] = upd_is_jmp ? 3 : 2;
                end
                if (k == 1 && upd_is_br) mghr[1] = (h * 2 + int'(upd_taken)) % 4;
                mbr[k]++;
                if (mis) mmiss[k]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        upd_vld = 1'b0; upd_is_br = 'x; upd_is_jmp = 'x; upd_pc = 'x;
        upd_taken = 'x; upd_target = 'x; upd_pred_taken = 'x; upd_pred_target = 'x;
        ghr0 = 'x; ghr1 = 'x;
    endtask

    task automatic resolve(input logic [31:0] pc, input bit jmp, input bit tk,
                           input logic [31:0] tg, input bit pt, input logic [31:0] ptg,
                           input logic [1:0] gh);
        upd_vld = 1'b1; upd_is_br = !jmp; upd_is_jmp = jmp; upd_pc = pc;
        upd_taken = tk; upd_target = tg; upd_pred_taken = pt; upd_pred_target = ptg;
        ghr0 = gh[0]; ghr1 = gh;
    endtask

    function automatic logic [31:0] rnd_pc();
        return ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2) |
               ($urandom_range(0, 1) << 20);
    endfunction

    initial begin
        rst = 1'b1; pc_f = 32'h0; idle();
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;

        // reset state
        pc_f = 32'h40; settle();
        check("t1.taken", 32'(b0.pred_taken_f), 32'd0);
        check("t1.target", b0.pred_target_f, 32'h44);
        check("t1.br_cnt", b0.br_cnt, 32'd0);
        check("t1.miss_cnt", b0.miss_cnt, 32'd0);
        tick();

        // first taken resolve allocates weakly-taken
        resolve(32'h40, 0, 1, 32'h100, 0, 32'h44, 2'd0); settle();
        check("t2.mis", 32'(b0.mispredict), 32'd1);
        check("t2.redirect", b0.redirect_pc, 32'h100);
        tick();
        idle(); settle();
        check("t2.taken", 32'(b0.pred_taken_f), 32'd1);
        check("t2.target", b0.pred_target_f, 32'h100);
        tick();

        // counter decrements, floors at 0, saturates at 3
        repeat (2) begin resolve(32'h40, 0, 0, 32'h100, 1, 32'h100, 2'd0); settle(); tick(); end
        idle(); settle();
        check("t3.nt", 32'(b0.pred_taken_f), 32'd0);
        tick();
        repeat (2) begin resolve(32'h40, 0, 0, 32'h100, 0, 32'h44, 2'd0); settle(); tick(); end
        resolve(32'h40, 0, 1, 32'h100, 0, 32'h44, 2'd0); settle(); tick();
        idle(); settle();
        check("t3.floor", 32'(b0.pred_taken_f), 32'd0);
        tick();
        repeat (3) begin resolve(32'h40, 0, 1, 32'h100, 0, 32'h44, 2'd0); settle(); tick(); end
        resolve(32'h40, 0, 0, 32'h100, 1, 32'h100, 2'd0); settle(); tick();
        idle(); settle();
        check("t3.sat", 32'(b0.pred_taken_f), 32'd1);
        tick();

        // aliasing tag replaces the entry
        pc_f = 32'h1040; settle();
        check("t4.alias_miss", b0.pred_target_f, 32'h1044);
        tick();
        resolve(32'h1040, 0, 1, 32'h200, 0, 32'h1044, 2'd0); settle(); tick();
        idle(); pc_f = 32'h40; settle();
        check("t4.old_miss", b0.pred_target_f, 32'h44);
        tick();
        pc_f = 32'h1040; settle();
        check("t4.new_hit", b0.pred_target_f, 32'h200);
        tick();

        // jalr retarget
        resolve(32'h80, 1, 1, 32'h300, 0, 32'h84, 2'd0); settle(); tick();
        idle(); pc_f = 32'h80; settle();
        check("t5.target", b0.pred_target_f, 32'h300);
        tick();
        resolve(32'h80, 1, 1, 32'h304, 1, 32'h300, 2'd0); settle();
        check("t5.mis", 32'(b0.mispredict), 32'd1);
        check("t5.redirect", b0.redirect_pc, 32'h304);
        tick();
        idle(); settle();
        check("t5.retarget", b0.pred_target_f, 32'h304);
        tick();

        // gshare history and same-cycle update/lookup
        rst = 1'b1; tick(); rst = 1'b0;
        resolve(32'h100, 0, 1, 32'h400, 0, 32'h104, 2'd0); settle(); tick();
        resolve(32'h104, 0, 0, 32'h400, 0, 32'h108, 2'd1); settle(); tick();
        idle(); pc_f = 32'h40; settle();
        check("t6.ghr", 32'(b1.pred_ghr_f), 32'd2);
        check("t6.bim_ghr", 32'(b0.pred_ghr_f), 32'd0);
        tick();
        resolve(32'h40, 1, 1, 32'h500, 0, 32'h44, 2'd2); settle();
        check("t6.pre_alloc", b1.pred_target_f, 32'h44);
        tick();
        idle(); settle();
        check("t6.idx2_hit", b1.pred_target_f, 32'h500);
        tick();
        resolve(32'h40, 1, 1, 32'h600, 1, 32'h500, 2'd2); settle();
        check("t6.old_data", b1.pred_target_f, 32'h500);
        tick();
        idle(); settle();
        check("t6.new_data", b1.pred_target_f, 32'h600);
        tick();

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(0, 199) == 0);
            pc_f = rnd_pc();
            if ($urandom_range(0, 2) != 0) begin
                logic [31:0] pc, tg, ptg;
                bit jmp, tk, pt;
                logic [1:0] gh;
                pc  = rnd_pc();
                jmp = ($urandom_range(0, 3) == 0);
                tk  = jmp ? 1'b1 : 1'($urandom_range(0, 1));
                tg  = 32'h1000 | ($urandom_range(0, 7) << 4);
                pt  = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 2))
                    0:       ptg = tg;
                    1:       ptg = pc + 32'd4;
                    default: ptg = 32'h1000 | ($urandom_range(0, 7) << 4);
                endcase
                gh = ($urandom_range(0, 1) != 0) ? 2'(mghr[1]) : 2'($urandom_range(0, 3));
                resolve(pc, jmp, tk, tg, pt, ptg, gh);
            end else begin
                idle();
            end
            settle();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
